m1553_manchester_decoder: RTL



---
 rtl/m1553_manchester_decoder.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/m1553_manchester_decoder.sv
// MIL-STD-1553 receive decoder: sync recognition plus Manchester decode of 16 data bits and parity.
// Optional M1553_DEC_ERR_CNT_EN adds a saturating o_err_count of Manchester and parity errors.
module m1553_manchester_decoder #(
    parameter int CLKS_PER_BIT = 20,
    parameter int TOL          = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_edge,
    input  logic        i_level,
    output logic        o_valid,
    output logic [15:0] o_data,
    output logic        o_sync_cmd,
    output logic        o_parity_err,
    output logic        o_manch_err,
    output logic        o_busy
`ifdef M1553_DEC_ERR_CNT_EN
    ,
    output logic [15:0] o_err_count
`endif
);
    localparam int N  = CLKS_PER_BIT;
    localparam int Q  = N / 4;
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(2 * N + 1);

    localparam logic [CW-1:0] C_WIN_LO   = CW'(3 * N / 2 - TOL);
    localparam logic [CW-1:0] C_WIN_HI   = CW'(3 * N / 2 + TOL);
    localparam logic [CW-1:0] C_SAT      = CW'(2 * N);
    localparam logic [CW-1:0] C_SYNC_END = CW'(3 * N / 2 - 1);
    localparam logic [PW-1:0] P_Q        = PW'(Q);
    localparam logic [PW-1:0] P_3Q       = PW'(3 * Q);
    localparam logic [PW-1:0] P_LAST     = PW'(N - 1);
    localparam logic [PW-1:0] P_RS_LO    = PW'(N / 2 - TOL);
    localparam logic [PW-1:0] P_RS_HI    = PW'(N / 2 + TOL);
    localparam logic [PW-1:0] P_RS_SET   = PW'(N / 2 + 1);

    // SYNC_B covers the 1.5 bit-times of second sync level after the mid-sync edge.
    typedef enum logic [1:0] {S_IDLE, S_SYNC_A, S_SYNC_B, S_DATA} state_t;

    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic          r_lvl_a, w_lvl_a_nx;
    logic [PW-1:0] r_phase, w_phase_nx;
    logic [4:0]    r_bit_cnt, w_bit_cnt_nx;
    logic          r_sample_a, w_sample_a_nx;
    logic [15:0]   r_shift, w_shift_nx;
    logic          r_sync_lvl, w_sync_lvl_nx;
    logic          r_valid, w_valid_nx;
    logic          r_manch_err, w_manch_err_nx;
    logic [15:0]   r_data, w_data_nx;
    logic          r_sync_cmd, w_sync_cmd_nx;
    logic          r_parity_err, w_parity_err_nx;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_lvl_a      <= 1'b0;
            r_phase      <= '0;
            r_bit_cnt    <= '0;
            r_sample_a   <= 1'b0;
            r_shift      <= '0;
            r_sync_lvl   <= 1'b0;
            r_valid      <= 1'b0;
            r_manch_err  <= 1'b0;
            r_data       <= '0;
            r_sync_cmd   <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_lvl_a      <= w_lvl_a_nx;
            r_phase      <= w_phase_nx;
            r_bit_cnt    <= w_bit_cnt_nx;
            r_sample_a   <= w_sample_a_nx;
            r_shift      <= w_shift_nx;
            r_sync_lvl   <= w_sync_lvl_nx;
            r_valid      <= w_valid_nx;
            r_manch_err  <= w_manch_err_nx;
            r_data       <= w_data_nx;
            r_sync_cmd   <= w_sync_cmd_nx;
            r_parity_err <= w_parity_err_nx;
        end
    end

    // r_cnt is cycles elapsed since the sync-start edge, the edge cycle itself being 0.
    always_comb begin
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt;
        w_lvl_a_nx      = r_lvl_a;
        w_phase_nx      = r_phase;
        w_bit_cnt_nx    = r_bit_cnt;
        w_sample_a_nx   = r_sample_a;
        w_shift_nx      = r_shift;
        w_sync_lvl_nx   = r_sync_lvl;
        w_valid_nx      = 1'b0;
        w_manch_err_nx  = 1'b0;
        w_data_nx       = r_data;
        w_sync_cmd_nx   = r_sync_cmd;
        w_parity_err_nx = r_parity_err;
        case (r_state)
            S_IDLE: begin
                if (i_edge) begin
                    w_state_nx = S_SYNC_A;
                    w_cnt_nx   = CW'(1);
                    w_lvl_a_nx = i_level;
                end
            end
            S_SYNC_A: begin
                if (i_edge && r_cnt >= C_WIN_LO && r_cnt <= C_WIN_HI) begin
                    w_state_nx    = S_SYNC_B;
                    w_cnt_nx      = CW'(1);
                    w_sync_lvl_nx = r_lvl_a;
                end else if (i_edge && r_cnt < C_WIN_LO) begin
                    w_cnt_nx   = CW'(1);
                    w_lvl_a_nx = i_level;
                end else if (r_cnt > C_WIN_HI) begin
                    w_state_nx = S_IDLE;
                end else begin
                    // Entry from a back-to-back word with no edge at the word boundary.
                    if (r_cnt == '0) w_lvl_a_nx = i_level;
                    w_cnt_nx = (r_cnt == C_SAT) ? r_cnt : r_cnt + 1'b1;
                end
            end
            S_SYNC_B: begin
                if (r_cnt == C_SYNC_END) begin
                    w_state_nx   = S_DATA;
                    w_phase_nx   = '0;
                    w_bit_cnt_nx = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (i_edge && r_phase >= P_RS_LO && r_phase <= P_RS_HI) w_phase_nx = P_RS_SET;
                else if (r_phase == P_LAST)                             w_phase_nx = '0;
                else                                                    w_phase_nx = r_phase + 1'b1;
                if (r_phase == P_Q) w_sample_a_nx = i_level;
                if (r_phase == P_3Q) begin
                    if (i_level == r_sample_a) begin
                        w_manch_err_nx = 1'b1;
                        w_state_nx     = S_IDLE;
                    end else begin
                        w_shift_nx = {r_shift[14:0], r_sample_a};
                        if (r_bit_cnt == 5'd16) begin
                            w_valid_nx      = 1'b1;
                            w_data_nx       = r_shift;
                            w_sync_cmd_nx   = r_sync_lvl;
                            w_parity_err_nx = ~(^{r_shift, r_sample_a});
                        end
                    end
                end
                if (r_phase == P_LAST && !(r_phase == P_3Q)) begin
                    if (r_bit_cnt == 5'd16) begin
                        w_state_nx = S_SYNC_A;
                        w_cnt_nx   = '0;
                    end else begin
                        w_bit_cnt_nx = r_bit_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    assign o_valid      = r_valid;
    assign o_data       = r_data;
    assign o_sync_cmd   = r_sync_cmd;
    assign o_parity_err = r_parity_err;
    assign o_manch_err  = r_manch_err;
    assign o_busy       = (r_state != S_IDLE);

`ifdef M1553_DEC_ERR_CNT_EN
    logic [15:0] r_err_count;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err_count <= '0;
        end else if ((r_manch_err || (r_valid && r_parity_err)) && r_err_count != 16'hFFFF) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end
    assign o_err_count = r_err_count;
`endif
endmodule
